// File: rtl/idli_fetch_buf_m_if.sv
// idli_fetch_buf_m_if
//   Bundles the fetch buffer's SQI-side and decode-side signals.
//   Signal names are written from the buffer's point of view (i_ = into the
//   buffer, o_ = out of the buffer).
//   Modports:
//     slave  : the fetch buffer itself
//     master : the surrounding logic (SQI read path + decode stage)
//   Parameter DEPTH sizes the occupancy field and must match the buffer.
interface idli_fetch_buf_m_if #(
  parameter int DEPTH = 8
) ();
  typedef logic [3:0] sqi_data_t;

  sqi_data_t                  i_fb_data;
  logic                       i_fb_data_vld;
  logic                       o_fb_rdy;
  logic                       i_fb_flush;
  sqi_data_t                  o_fb_data;
  logic                       o_fb_vld;
  logic                       i_fb_acp;
  logic                       o_fb_sow;
  logic [$clog2(DEPTH):0]     o_fb_cnt;
  logic                       o_fb_ovf;

  modport slave (
    input  i_fb_data, i_fb_data_vld, i_fb_flush, i_fb_acp,
    output o_fb_rdy, o_fb_data, o_fb_vld, o_fb_sow, o_fb_cnt, o_fb_ovf
  );

  modport master (
    output i_fb_data, i_fb_data_vld, i_fb_flush, i_fb_acp,
    input  o_fb_rdy, o_fb_data, o_fb_vld, o_fb_sow, o_fb_cnt, o_fb_ovf
  );
endinterface

// File: rtl/idli_fetch_buf_m.sv
// idli_fetch_buf_m
//   Nibble-wide circular fetch FIFO between the SQI read path and decode.
//   Tracks the position of the head nibble within a 16-bit instruction word
//   (4 nibbles), raises back-pressure when free space drops below
//   RDY_MARGIN, and records a sticky overflow when a nibble is dropped.
//
//   Ports:
//     i_fb_gck    core clock
//     i_fb_rst_n  asynchronous active-low reset
//     fb          idli_fetch_buf_m_if.slave:
//                   i_fb_data/i_fb_data_vld  nibble stream from SQI
//                   o_fb_rdy                 SQI may keep streaming
//                   i_fb_flush               discard contents, realign
//                   o_fb_data/o_fb_vld       head nibble to decode
//                   i_fb_acp                 decode pops head nibble
//                   o_fb_sow                 head is nibble 0 of a word
//                   o_fb_cnt                 occupancy in nibbles
//                   o_fb_ovf                 sticky drop indicator
//
//   Build option: define IDLI_FB_BYPASS_EN to forward an incoming nibble
//   straight to the output while the buffer is empty. Without it there is
//   no combinational path from the inputs to o_fb_data/o_fb_vld.
module idli_fetch_buf_m #(
  parameter int DEPTH      = 8,
  parameter int RDY_MARGIN = 2
) (
  input  logic             i_fb_gck,
  input  logic             i_fb_rst_n,
  idli_fetch_buf_m_if.slave fb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_ovf;
  logic          r_rdy;

  logic          w_empty;
  logic          w_full;
  logic          w_vld;
  logic [3:0]    w_data;
  logic          w_pop;
  logic          w_push;
  logic          w_wr;
  logic          w_ovf_set;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_rdy_nxt;

  // Head selection / handshake decode (combinational, from registered state)
  always_comb begin
    w_empty = (r_cnt == '0);
    w_full  = (r_cnt == CW'(DEPTH));
`ifdef IDLI_FB_BYPASS_EN
    w_vld  = !w_empty || fb.i_fb_data_vld;
    if (!w_empty)
      w_data = r_mem[r_rptr];
    else if (fb.i_fb_data_vld)
      w_data = fb.i_fb_data;
    else
      w_data = 4'h0;
`else
    w_vld  = !w_empty;
    w_data = w_empty ? 4'h0 : r_mem[r_rptr];
`endif
    // Flush cancels both sides of the handshake in the same cycle.
    w_pop     = w_vld && fb.i_fb_acp && !fb.i_fb_flush;
    w_push    = fb.i_fb_data_vld && (!w_full || w_pop) && !fb.i_fb_flush;
    w_ovf_set = fb.i_fb_data_vld && w_full && !w_pop && !fb.i_fb_flush;
    // A bypassed nibble (empty + push + pop) never needs the array.
    w_wr      = w_push && !(w_empty && w_pop);

    w_cnt_nxt = r_cnt;
    if (fb.i_fb_flush)
      w_cnt_nxt = '0;
    else if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_pop && !w_push)
      w_cnt_nxt = r_cnt - CW'(1);

    // Registering this makes o_fb_rdy describe the same occupancy as o_fb_cnt.
    w_rdy_nxt = (DEPTH - int'(w_cnt_nxt)) >= RDY_MARGIN;
  end

  // Storage array: data only, no reset needed
  always_ff @(posedge i_fb_gck) begin
    if (w_wr)
      r_mem[r_wptr] <= fb.i_fb_data;
  end

  // Control state
  always_ff @(posedge i_fb_gck or negedge i_fb_rst_n) begin
    if (!i_fb_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      r_rdy  <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= w_rdy_nxt;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      if (fb.i_fb_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_idx  <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + PW'(1);
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
          r_idx  <= r_idx + 2'd1;
        end
      end
    end
  end

  assign fb.o_fb_data = w_data;
  assign fb.o_fb_vld  = w_vld;
  assign fb.o_fb_sow  = (r_idx == 2'd0) && w_vld;
  assign fb.o_fb_cnt  = r_cnt;
  assign fb.o_fb_ovf  = r_ovf;
  assign fb.o_fb_rdy  = r_rdy;

endmodule

// File: tb/tb_idli_fetch_buf_m.sv
module tb_idli_fetch_buf_m;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
`ifdef IDLI_FB_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  logic clk;
  logic rst_n;

  idli_fetch_buf_m_if #(.DEPTH(DEPTH)) fb_if ();

  idli_fetch_buf_m #(.DEPTH(DEPTH), .RDY_MARGIN(MARGIN)) dut (
    .i_fb_gck   (clk),
    .i_fb_rst_n (rst_n),
    .fb         (fb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       acp;
    logic       fl;
    logic       vld;
    logic [3:0] dat;
    logic [3:0] cnt;
    logic       sow;
    logic       ovf;
    logic       rdy;
  } vec_t;

  vec_t tbl [28];

  // Reference model state: contents as a queue, word position, sticky drop.
  logic [3:0] q[$];
  int         m_idx;
  bit         m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [3:0] dat,
                           input logic [3:0] cnt, input logic sow, input logic ovf,
                           input logic rdy);
    chk({tag, ".vld"},  32'(fb_if.o_fb_vld),  32'(vld));
    chk({tag, ".data"}, 32'(fb_if.o_fb_data), 32'(dat));
    chk({tag, ".cnt"},  32'(fb_if.o_fb_cnt),  32'(cnt));
    chk({tag, ".sow"},  32'(fb_if.o_fb_sow),  32'(sow));
    chk({tag, ".ovf"},  32'(fb_if.o_fb_ovf),  32'(ovf));
    chk({tag, ".rdy"},  32'(fb_if.o_fb_rdy),  32'(rdy));
  endtask

  // Apply inputs just after the active edge; caller samples at the falling edge.
  task automatic drive(input logic dv, input logic [3:0] d, input logic acp, input logic fl);
    @(posedge clk);
    #1;
    fb_if.i_fb_data_vld = dv;
    fb_if.i_fb_data     = d;
    fb_if.i_fb_acp      = acp;
    fb_if.i_fb_flush    = fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fb_if.i_fb_data_vld = 1'b0;
    fb_if.i_fb_data     = 4'h0;
    fb_if.i_fb_acp      = 1'b0;
    fb_if.i_fb_flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
  endtask

  function automatic vec_t mk(input logic dv, input logic [3:0] d, input logic acp,
                              input logic fl, input logic vld, input logic [3:0] dat,
                              input logic [3:0] cnt, input logic sow, input logic ovf,
                              input logic rdy);
    vec_t v;
    v.dv = dv; v.d = d; v.acp = acp; v.fl = fl;
    v.vld = vld; v.dat = dat; v.cnt = cnt; v.sow = sow; v.ovf = ovf; v.rdy = rdy;
    return v;
  endfunction

  // One cycle of the reference model: check current outputs, then advance.
  task automatic model_cycle(input logic dv, input logic [3:0] d, input logic acp,
                             input logic fl);
    logic       ev, es, erdy;
    logic [3:0] ed;
    bit         pop, room;
    ev   = (q.size() > 0) || (B && dv);
    ed   = (q.size() > 0) ? q[0] : ((B && dv) ? d : 4'h0);
    es   = ev && (m_idx == 0);
    erdy = (DEPTH - q.size()) >= MARGIN;
    check_out("rand", ev, ed, 4'(q.size()), es, m_ovf, erdy);
    if (fl) begin
      q.delete();
      m_idx = 0;
    end else begin
      pop  = ev && acp;
      room = (q.size() < DEPTH) || pop;
      if (dv && !room) m_ovf = 1'b1;
      if (!(pop && q.size() == 0)) begin
        if (pop) void'(q.pop_front());
        if (dv && room) q.push_back(d);
      end
      if (pop) m_idx = (m_idx + 1) % 4;
    end
  endtask

  initial begin
    logic dv, acp, fl;
    logic [3:0] d;
    int pdv, pacp;

    rst_n = 1'b0;
    fb_if.i_fb_data_vld = 1'b0;
    fb_if.i_fb_data     = 4'h0;
    fb_if.i_fb_acp      = 1'b0;
    fb_if.i_fb_flush    = 1'b0;

    //                dv    d     acp   fl   | vld   dat                cnt   sow   ovf   rdy
    tbl[0]  = mk(1'b1, 4'h1, 1'b0, 1'b0, B,    B ? 4'h1 : 4'h0, 4'd0, B,    1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h1,            4'd1, 1'b1, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'h1,            4'd2, 1'b1, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'h1,            4'd3, 1'b1, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h1,            4'd4, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2,            4'd3, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h3,            4'd2, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4,            4'd1, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 4'h5, 1'b0, 1'b0, B,    B ? 4'h5 : 4'h0, 4'd0, B,    1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 4'h5,            4'd1, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 4'h6,            4'd1, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 4'h7,            4'd1, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h8,            4'd1, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0,            4'd0, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 4'hC, 1'b0, 1'b0, B,    B ? 4'hC : 4'h0, 4'd0, B,    1'b0, 1'b1);
    tbl[15] = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'hC,            4'd1, 1'b1, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'hC,            4'd2, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'hC,            4'd3, 1'b1, 1'b0, 1'b1);
    tbl[18] = mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'hC,            4'd4, 1'b1, 1'b0, 1'b1);
    tbl[19] = mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'hC,            4'd5, 1'b1, 1'b0, 1'b1);
    tbl[20] = mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'hC,            4'd6, 1'b1, 1'b0, 1'b1);
    tbl[21] = mk(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 4'hC,            4'd7, 1'b1, 1'b0, 1'b0);
    tbl[22] = mk(1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 4'hC,            4'd8, 1'b1, 1'b0, 1'b0);
    tbl[23] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1,            4'd8, 1'b0, 1'b0, 1'b0);
    tbl[24] = mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'h1,            4'd8, 1'b0, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1,            4'd8, 1'b0, 1'b1, 1'b0);
    tbl[26] = mk(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 4'h1,            4'd8, 1'b0, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0,            4'd0, 1'b0, 1'b1, 1'b1);

    // Reset state
    do_reset();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check_out("reset", 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Table: ordering, word alignment, full, overflow, flush
    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].dv, tbl[i].d, tbl[i].acp, tbl[i].fl);
      check_out($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].dat, tbl[i].cnt,
                tbl[i].sow, tbl[i].ovf, tbl[i].rdy);
    end

    // Mid-word flush: 5 pushed, 2 popped (3 held, word index 2), flush with push+pop
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 4'h7, 1'b1, 1'b1);
    chk("mwf.pre_cnt", 32'(fb_if.o_fb_cnt), 32'd3);
    chk("mwf.pre_sow", 32'(fb_if.o_fb_sow), 32'd0);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    chk("mwf.cnt", 32'(fb_if.o_fb_cnt), 32'd0);
    chk("mwf.vld", 32'(fb_if.o_fb_vld), 32'(B));
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check_out("mwf.next", 1'b1, 4'h6, 4'd1, 1'b1, 1'b0, 1'b1);

    // Bypass / latency check on an empty buffer
    do_reset();
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    chk("byp.vld0",  32'(fb_if.o_fb_vld),  32'(B));
    chk("byp.data0", 32'(fb_if.o_fb_data), B ? 32'h9 : 32'h0);
    chk("byp.cnt0",  32'(fb_if.o_fb_cnt),  32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("byp.vld1",  32'(fb_if.o_fb_vld),  32'(!B));
    chk("byp.data1", 32'(fb_if.o_fb_data), B ? 32'h0 : 32'h9);
    chk("byp.cnt1",  32'(fb_if.o_fb_cnt),  B ? 32'd0 : 32'd1);

    // Randomized traffic against the queue model, with shifting bias
    do_reset();
    pdv = 70; pacp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ((c / 200) % 3)
          0: begin pdv = 80; pacp = 30; end
          1: begin pdv = 40; pacp = 80; end
          default: begin pdv = 70; pacp = 65; end
        endcase
      end
      dv  = ($urandom_range(99) < pdv);
      acp = ($urandom_range(99) < pacp);
      fl  = ($urandom_range(99) < 2);
      d   = 4'($urandom);
      drive(dv, d, acp, fl);
      model_cycle(dv, d, acp, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
